// File: rtl/tictoc_ascii_tx.sv
// Streams each new TicToc result to the UART as four ASCII hex digits plus a terminator.
// Build option TICTOC_ASCII_CRLF_EN: terminate with CR LF (6 bytes) instead of one space (5 bytes).
module tictoc_ascii_tx #(
    parameter bit UPPERCASE_HEX = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] TicToc_Arr,
    input  logic        TicToc_ready,
    input  logic        Tx_busy,
    output logic [7:0]  Tx_data,
    output logic        Tx_start,
    output logic        TicToc_ASCII_TX_done,
    output logic        Overrun
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 16;
`ifdef TICTOC_ASCII_CRLF_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  cap_q, cap_d;
    logic               ready_q;
    logic [7:0]         data_q, data_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic               rise_c;
    logic [7:0]         byte_c;

    assign rise_c = TicToc_ready & ~ready_q;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] base;
        if (nib < 4'd10) begin
            return 8'h30 + 8'(nib);
        end
        base = UPPERCASE_HEX ? 8'h41 : 8'h61;
        return base + 8'(nib) - 8'd10;
    endfunction

    // Byte for the current message position, taken from the frozen capture.
    always_comb begin
        byte_c = 8'h00;
        case (idx_q)
            IDX_W'(0): byte_c = hex_ascii(cap_q[15:12]);
            IDX_W'(1): byte_c = hex_ascii(cap_q[11:8]);
            IDX_W'(2): byte_c = hex_ascii(cap_q[7:4]);
            IDX_W'(3): byte_c = hex_ascii(cap_q[3:0]);
`ifdef TICTOC_ASCII_CRLF_EN
            IDX_W'(4): byte_c = 8'h0D;
            IDX_W'(5): byte_c = 8'h0A;
`else
            IDX_W'(4): byte_c = 8'h20;
`endif
            default:   byte_c = 8'h00;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (rise_c) state_d = S_LOAD;
            S_LOAD:    state_d = S_SEND;
            S_SEND:    if (start_q) state_d = S_WAIT_HI;
            S_WAIT_HI: if (Tx_busy) state_d = S_WAIT_LO;
            S_WAIT_LO: if (!Tx_busy) state_d = (idx_q == LAST_IDX) ? S_DONE : S_LOAD;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Start is registered: it is requested from LOAD/SEND when the UART is idle and shows up in SEND.
    always_comb begin
        idx_d     = idx_q;
        cap_d     = cap_q;
        data_d    = data_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun_q | (rise_c & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (rise_c) begin
                    cap_d = TicToc_Arr;
                    idx_d = '0;
                end
            end
            S_LOAD: begin
                data_d  = byte_c;
                start_d = ~Tx_busy;
            end
            S_SEND: begin
                start_d = ~Tx_busy & ~start_q;
            end
            S_WAIT_LO: begin
                if (!Tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx_q     <= '0;
            cap_q     <= '0;
            ready_q   <= 1'b0;
            data_q    <= 8'h00;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            cap_q     <= cap_d;
            ready_q   <= TicToc_ready;
            data_q    <= data_d;
            start_q   <= start_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign Tx_data              = data_q;
    assign Tx_start             = start_q;
    assign TicToc_ASCII_TX_done = done_q;
    assign Overrun              = overrun_q;

endmodule

// File: tb/tb_tictoc_ascii_tx.sv
// Directed bench for tictoc_ascii_tx with a behavioural UART busy model (10 cycles per byte).
module tb_tictoc_ascii_tx;

    localparam int BUSY_LEN = 10;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] TicToc_Arr = 16'h0000;
    logic        TicToc_ready = 1'b0;
    logic        Tx_busy;
    logic [7:0]  Tx_data;
    logic        Tx_start;
    logic        done;
    logic        Overrun;

    logic        model_busy = 1'b0;
    logic        hold_busy = 1'b0;
    int          busy_cnt = 0;
    logic        start_prev = 1'b0;
    logic        busy_prev_n = 1'b0;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          start_cnt = 0;
    int          done_cnt = 0;
    int          start_busy_err = 0;
    int          start_dbl_err = 0;
    int          cyc_n = 0;
    int          fall_n = 0;
    int          done_n = 0;

    int          n_checks = 0;
    int          n_pass = 0;

    assign Tx_busy = model_busy | hold_busy;

    tictoc_ascii_tx dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .TicToc_Arr           (TicToc_Arr),
        .TicToc_ready         (TicToc_ready),
        .Tx_busy              (Tx_busy),
        .Tx_data              (Tx_data),
        .Tx_start             (Tx_start),
        .TicToc_ASCII_TX_done (done),
        .Overrun              (Overrun)
    );

    always #5 Clk = ~Clk;

    // UART model: accepts a start, goes busy the next cycle for BUSY_LEN cycles, logs the byte.
    always @(posedge Clk) begin
        if (Tx_start) begin
            got_q.push_back(Tx_data);
            start_cnt++;
            if (Tx_busy) start_busy_err++;
            if (start_prev) start_dbl_err++;
            model_busy <= 1'b1;
            busy_cnt   <= BUSY_LEN;
        end else if (model_busy) begin
            if (busy_cnt <= 1) model_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end
        start_prev <= Tx_start;
        if (done) done_cnt++;
    end

    always @(negedge Clk) begin
        cyc_n++;
        if (!Tx_busy && busy_prev_n) fall_n = cyc_n;
        if (done) done_n = cyc_n;
        busy_prev_n = Tx_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic set_exp(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        exp_q.delete();
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
`ifdef TICTOC_ASCII_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        exp_q.push_back(8'h20);
`endif
    endtask

    task automatic raise(input logic [15:0] v);
        TicToc_Arr   = v;
        TicToc_ready = 1'b1;
        tick(3);
        TicToc_ready = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic wait_starts(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (start_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(2);
        n_checks++; if (Tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", Tx_data); else n_pass++;
        n_checks++; if (Tx_start !== 1'b0) $display("FAIL reset_tx_start got=%b exp=0", Tx_start); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (Overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", Overrun); else n_pass++;
        Reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        logic [7:0] g;
        got_q.delete();
        d0 = done_cnt;
        set_exp(8'h39, 8'h43, 8'h42, 8'h35);
        TicToc_Arr   = 16'h9CB5;
        TicToc_ready = 1'b1;
        @(negedge Clk);
        n_checks++; if (Tx_start !== 1'b0) $display("FAIL basic_load_no_start got=%b exp=0", Tx_start); else n_pass++;
        @(negedge Clk);
        n_checks++; if (Tx_start !== 1'b1) $display("FAIL basic_first_start got=%b exp=1", Tx_start); else n_pass++;
        n_checks++; if (Tx_data !== 8'h39) $display("FAIL basic_first_byte got=%h exp=39", Tx_data); else n_pass++;
        tick(2);
        TicToc_ready = 1'b0;
        TicToc_Arr   = 16'h0000;
        wait_done(d0, ok);
        n_checks++; if (!ok) $display("FAIL basic_done_timeout got=no_done exp=done"); else n_pass++;
        tick(5);
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL basic_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
        end
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); else n_pass++;
        n_checks++; if (done_n - fall_n != 1) $display("FAIL basic_done_latency got=%0d exp=1", done_n - fall_n); else n_pass++;
        n_checks++; if (Overrun !== 1'b0) $display("FAIL basic_overrun got=%b exp=0", Overrun); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        int s0;
        logic [7:0] g;
        got_q.delete();
        d0 = done_cnt;
        s0 = start_cnt;
        set_exp(8'h30, 8'h30, 8'h30, 8'h30);
        raise(16'h0000);
        wait_done(d0, ok);
        n_checks++; if (!ok) $display("FAIL b2b_first_timeout got=no_done exp=done"); else n_pass++;
        n_checks++; if (start_cnt - s0 != exp_q.size()) $display("FAIL b2b_first_starts got=%0d exp=%0d", start_cnt - s0, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL b2b_first_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
        end
        got_q.delete();
        d0 = done_cnt;
        set_exp(8'h46, 8'h46, 8'h46, 8'h46);
        tick(1);
        raise(16'hFFFF);
        wait_done(d0, ok);
        n_checks++; if (!ok) $display("FAIL b2b_second_timeout got=no_done exp=done"); else n_pass++;
        tick(3);
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL b2b_second_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL b2b_second_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_overrun();
        bit ok;
        int d0;
        int s0;
        logic [7:0] g;
        got_q.delete();
        d0 = done_cnt;
        s0 = start_cnt;
        set_exp(8'h39, 8'h43, 8'h42, 8'h35);
        raise(16'h9CB5);
        wait_starts(s0 + 2, ok);
        n_checks++; if (!ok) $display("FAIL ovr_start_timeout got=no_start exp=start"); else n_pass++;
        tick(2);
        TicToc_Arr   = 16'h1234;
        TicToc_ready = 1'b1;
        tick(1);
        n_checks++; if (Overrun !== 1'b1) $display("FAIL ovr_flag got=%b exp=1", Overrun); else n_pass++;
        tick(2);
        TicToc_ready = 1'b0;
        wait_done(d0, ok);
        n_checks++; if (!ok) $display("FAIL ovr_done_timeout got=no_done exp=done"); else n_pass++;
        tick(60);
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL ovr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL ovr_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
        end
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL ovr_done_pulses got=%0d exp=1", done_cnt - d0); else n_pass++;
        n_checks++; if (Overrun !== 1'b1) $display("FAIL ovr_sticky got=%b exp=1", Overrun); else n_pass++;
    endtask

    task automatic test_busy_hold();
        bit ok;
        int d0;
        int early;
        logic [7:0] g;
        got_q.delete();
        d0 = done_cnt;
        early = 0;
        set_exp(8'h31, 8'h41, 8'h32, 8'h42);
        hold_busy    = 1'b1;
        TicToc_Arr   = 16'h1A2B;
        TicToc_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (i == 2) TicToc_ready = 1'b0;
            if (Tx_start) early++;
        end
        n_checks++; if (early != 0) $display("FAIL hold_no_start got=%0d exp=0", early); else n_pass++;
        hold_busy = 1'b0;
        @(negedge Clk);
        n_checks++; if (Tx_start !== 1'b1) $display("FAIL hold_release_start got=%b exp=1", Tx_start); else n_pass++;
        n_checks++; if (Tx_data !== 8'h31) $display("FAIL hold_release_byte got=%h exp=31", Tx_data); else n_pass++;
        wait_done(d0, ok);
        n_checks++; if (!ok) $display("FAIL hold_done_timeout got=no_done exp=done"); else n_pass++;
        tick(3);
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL hold_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        int s0;
        logic [7:0] g;
        got_q.delete();
        s0 = start_cnt;
        raise(16'h9CB5);
        wait_starts(s0 + 4, ok);
        n_checks++; if (!ok) $display("FAIL rstmid_start_timeout got=no_start exp=start"); else n_pass++;
        tick(4);
        #2 Reset = 1'b1;
        #1;
        n_checks++; if (Tx_data !== 8'h00) $display("FAIL rstmid_tx_data got=%h exp=00", Tx_data); else n_pass++;
        n_checks++; if (Tx_start !== 1'b0) $display("FAIL rstmid_tx_start got=%b exp=0", Tx_start); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (Overrun !== 1'b0) $display("FAIL rstmid_overrun got=%b exp=0", Overrun); else n_pass++;
        tick(2);
        Reset = 1'b0;
        d0 = done_cnt;
        s0 = start_cnt;
        tick(30);
        n_checks++; if (done_cnt != d0) $display("FAIL rstmid_no_done got=%0d exp=%0d", done_cnt, d0); else n_pass++;
        n_checks++; if (start_cnt != s0) $display("FAIL rstmid_no_start got=%0d exp=%0d", start_cnt, s0); else n_pass++;
        got_q.delete();
        set_exp(8'h42, 8'h45, 8'h45, 8'h46);
        raise(16'hBEEF);
        wait_done(d0, ok);
        n_checks++; if (!ok) $display("FAIL rstmid_fresh_timeout got=no_done exp=done"); else n_pass++;
        tick(3);
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL rstmid_fresh_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL rstmid_fresh_byte%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_protocol();
        n_checks++; if (start_busy_err != 0) $display("FAIL proto_start_while_busy got=%0d exp=0", start_busy_err); else n_pass++;
        n_checks++; if (start_dbl_err != 0) $display("FAIL proto_double_start got=%0d exp=0", start_dbl_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_busy_hold();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tictoc_ascii_tx.md
# tictoc_ascii_tx

Downstream stage of the TicToc interval timer. On each new `TicToc_Arr` result flagged by `TicToc_ready`, converts the 16-bit value to four ASCII hex characters plus an optional line terminator. Streams the bytes one at a time into the byte-wide UART transmitter. Pulses `TicToc_ASCII_TX_done` back to TicToc when the last byte has left the UART.

## Interface
- `UPPERCASE_HEX`, default 1: 1 emits `A`–`F` (0x41–0x46); 0 emits `a`–`f` (0x61–0x66).
- `Clk` in 1: single system clock, all logic on rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `TicToc_Arr` in 16: measured interval from TicToc; valid while `TicToc_ready`=1.
- `TicToc_ready` in 1: level from TicToc; a 0→1 transition marks a new result.
- `Tx_busy` in 1: UART busy. Rises the cycle after an accepted `Tx_start` and falls when the stop bit ends.
- `Tx_data` out 8: byte to UART; stable from `Tx_start` until the byte completes.
- `Tx_start` out 1: one-cycle pulse requesting transmission of `Tx_data`.
- `TicToc_ASCII_TX_done` out 1: one-cycle pulse when the full message has been sent.
- `Overrun` out 1: sticky; set when a new `TicToc_ready` rise arrives while not IDLE. Cleared only by `Reset`.

## Operation
- Reset values: `Tx_data`=0x00, `Tx_start`=0, `TicToc_ASCII_TX_done`=0, `Overrun`=0. State=IDLE, byte index=0, capture register=0, `TicToc_ready` edge register=0.
- Edge detect: `rise = TicToc_ready & ~ready_q`. `ready_q` is registered every cycle.
- States:
  - IDLE: on `rise`, capture `TicToc_Arr` into a 16-bit register, set index=0, go to LOAD.
  - LOAD: drive `Tx_data` = ASCII of nibble [15:12], [11:8], [7:4], [3:0] for index 0–3. Index 4 and 5 are terminator bytes. Go to SEND.
  - SEND: if `Tx_busy`=0, pulse `Tx_start` and go to WAIT_HI; otherwise hold in SEND.
  - WAIT_HI: wait for `Tx_busy`=1, then go to WAIT_LO.
  - WAIT_LO: wait for `Tx_busy`=0. If index = last, go to DONE; else index+1 and go to LOAD.
  - DONE: pulse `TicToc_ASCII_TX_done`, go to IDLE.
- Nibble mapping: 0–9 → 0x30+n; 10–15 → (`UPPERCASE_HEX` ? 0x41 : 0x61)+n−10.
- A `rise` in any state other than IDLE is dropped: no capture, `Overrun`←1.
- A `rise` in the same cycle as the DONE→IDLE transition is also an overrun. IDLE must see the rise in a later cycle to accept it.
- The captured value is frozen for the whole message; `TicToc_Arr` changes after capture have no effect.
- Reset mid-message: immediate return to IDLE with all outputs at reset values. No done pulse is produced, and the partial message is abandoned.

## Timing
- Cycle n: `TicToc_ready` is sampled high with `ready_q`=0 in IDLE.
- n+1: LOAD.
- n+2: `Tx_start`=1 and first byte on `Tx_data`, given `Tx_busy`=0.
- Per byte: Tx_start → WAIT_HI (≥1 cycle) → WAIT_LO (until busy falls) → LOAD → SEND. That is 2 cycles of overhead after `Tx_busy` falls.
- `TicToc_ASCII_TX_done` is high exactly 1 cycle, 1 cycle after `Tx_busy` falls on the last byte.
- `Tx_start` is never asserted while `Tx_busy`=1, and is never high on two consecutive cycles.

## Configuration
- Macro `TICTOC_ASCII_CRLF_EN`.
- Defined: message is 6 bytes, four hex characters then 0x0D, 0x0A; last index = 5.
- Undefined: message is 5 bytes, four hex characters then 0x20 (space); last index = 4. No CR/LF logic is compiled.

## Test plan
- `TicToc_Arr`=0x9CB5 with a ready rise, UART model busy 10 cycles per byte, CRLF_EN defined → `Tx_data` sequence 0x39,0x43,0x42,0x35,0x0D,0x0A. Exactly 6 `Tx_start` pulses, then one done pulse; `Overrun`=0.
- Same stimulus, `UPPERCASE_HEX`=0, CRLF_EN undefined → 0x39,0x63,0x62,0x35,0x20, then done.
- `TicToc_Arr`=0x0000 then 0xFFFF as two successive messages → "0000" then "FFFF". The second message starts only after the first done pulse.
- Second ready rise injected during byte 2 → that rise is ignored and `Overrun`=1 (sticky). The first message completes unchanged with 0x9CB5 bytes.
- `Tx_busy` held high 50 cycles before the first byte → `Tx_start` stays 0 until busy drops, then pulses within 1 cycle.
- `Reset` asserted during WAIT_LO of byte 3 → outputs go to reset values immediately and no done pulse occurs. A new ready rise after reset sends a complete fresh message.
